// File: rtl/bus_arbiter.sv
// Two-device bus arbiter: registered grants, tie-break against the last owner, registered bus mux.
// Optional macro BUS_ARB_BURST_LIMIT_EN caps an owner at MAX_BURST cycles while the other device waits.
module bus_arbiter #(
    parameter int N         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_1,
    input  logic         req_2,
    input  logic [N-1:0] data_in_1,
    input  logic [N-1:0] data_in_2,
    output logic         grant_1,
    output logic         grant_2,
    output logic         sel,
    output logic [N-1:0] bus,
    output logic         bus_valid
);

    typedef enum logic [1:0] {IDLE, OWN1, OWN2, TURN} state_t;

    state_t         state_q, state_d;
    logic           last2_q, last2_d;   // 1: device 2 owned last, so device 1 wins the next tie
    logic           grant1_q, grant2_q, sel_q, valid_q;
    logic [N-1:0]   bus_q;
    logic           lim1, lim2;

`ifdef BUS_ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    assign lim1 = (cnt_q == CW'(MAX_BURST)) && req_2;
    assign lim2 = (cnt_q == CW'(MAX_BURST)) && req_1;

    always_comb begin
        cnt_d = '0;
        if (state_d == OWN1 || state_d == OWN2) begin
            if (state_q == IDLE || state_q == TURN)
                cnt_d = CW'(1);
            else if (cnt_q == CW'(MAX_BURST))
                cnt_d = cnt_q;
            else
                cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign lim1 = 1'b0;
    assign lim2 = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last2_d = last2_q;
        case (state_q)
            IDLE, TURN: begin
                if (req_1 && (!req_2 || last2_q)) begin
                    state_d = OWN1;
                    last2_d = 1'b0;
                end else if (req_2) begin
                    state_d = OWN2;
                    last2_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN1:    if (!req_1 || lim1) state_d = TURN;
            OWN2:    if (!req_2 || lim2) state_d = TURN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last2_q  <= 1'b1;
            grant1_q <= 1'b0;
            grant2_q <= 1'b0;
            sel_q    <= 1'b0;
            bus_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last2_q  <= last2_d;
            grant1_q <= (state_d == OWN1);
            grant2_q <= (state_d == OWN2);
            if (state_d == OWN1)
                sel_q <= 1'b0;
            else if (state_d == OWN2)
                sel_q <= 1'b1;
            // Datapath follows the current owner, so bus lags the grant by one cycle.
            case (state_q)
                OWN1: begin
                    bus_q   <= data_in_1;
                    valid_q <= 1'b1;
                end
                OWN2: begin
                    bus_q   <= data_in_2;
                    valid_q <= 1'b1;
                end
                default: valid_q <= 1'b0;
            endcase
        end
    end

    assign grant_1   = grant1_q;
    assign grant_2   = grant2_q;
    assign sel       = sel_q;
    assign bus       = bus_q;
    assign bus_valid = valid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (N=8, MAX_BURST=4); expectations follow the build's BUS_ARB_BURST_LIMIT_EN setting.
module tb_bus_arbiter;

    logic       clk;
    logic       rst;
    logic       req_1, req_2;
    logic [7:0] data_in_1, data_in_2;
    logic       grant_1, grant_2, sel, bus_valid;
    logic [7:0] bus;

    int total;
    int bad;

    bus_arbiter #(.N(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_1     (req_1),
        .req_2     (req_2),
        .data_in_1 (data_in_1),
        .data_in_2 (data_in_2),
        .grant_1   (grant_1),
        .grant_2   (grant_2),
        .sel       (sel),
        .bus       (bus),
        .bus_valid (bus_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic g1, input logic g2, input logic s, input logic v);
        chk({tag, ".grant_1"}, {7'd0, grant_1}, {7'd0, g1});
        chk({tag, ".grant_2"}, {7'd0, grant_2}, {7'd0, g2});
        chk({tag, ".sel"}, {7'd0, sel}, {7'd0, s});
        chk({tag, ".bus_valid"}, {7'd0, bus_valid}, {7'd0, v});
    endtask

    initial begin
        logic exp_g1, exp_g2, exp_v, prev_own;
        int   ph;
        total = 0;
        bad   = 0;
        rst = 1'b1; req_1 = 1'b0; req_2 = 1'b0;
        data_in_1 = 8'h00; data_in_2 = 8'h00;
        tick();
        tick();
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.bus", bus, 8'h00);
        rst = 1'b0;
        tick();
        chk_out("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Single requester, three cycles of ownership.
        req_1 = 1'b1; data_in_1 = 8'h11;
        tick();
        chk_out("solo.e1", 1'b1, 1'b0, 1'b0, 1'b0);
        data_in_1 = 8'h22;
        tick();
        chk_out("solo.e2", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("solo.e2.bus", bus, 8'h22);
        data_in_1 = 8'h33;
        tick();
        chk_out("solo.e3", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("solo.e3.bus", bus, 8'h33);
        req_1 = 1'b0; data_in_1 = 8'h44;
        tick();
        chk_out("solo.turn", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("solo.turn.bus", bus, 8'h44);
        data_in_1 = 8'h55;
        tick();
        chk_out("solo.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("solo.idle.bus", bus, 8'h44);

        // Simultaneous requests after reset: device 1 first, one TURN, then device 2.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_1 = 1'b1; req_2 = 1'b1; data_in_1 = 8'h61; data_in_2 = 8'hB2;
        tick();
        chk_out("tie.own1", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("tie.own1b", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("tie.own1b.bus", bus, 8'h61);
        req_1 = 1'b0;
        tick();
        chk_out("tie.turn", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("tie.own2", 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset during the second cycle of an OWN2 burst.
        data_in_2 = 8'hA5;
        tick();
        chk_out("rst.own2c2", 1'b0, 1'b1, 1'b1, 1'b1);
        chk("rst.own2c2.bus", bus, 8'hA5);
        rst = 1'b1;
        tick();
        chk_out("rst.abort", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.abort.bus", bus, 8'h00);
        req_1 = 1'b1;
        tick();
        chk_out("rst.held", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("rst.release", 1'b1, 1'b0, 1'b0, 1'b0);

        // Both requests held high continuously.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_1 = 1'b1; req_2 = 1'b1;
        prev_own = 1'b0;
        for (int t = 0; t < 14; t++) begin
            tick();
`ifdef BUS_ARB_BURST_LIMIT_EN
            ph = t % 10;
            exp_g1 = (ph < 4);
            exp_g2 = (ph >= 5) && (ph < 9);
`else
            ph = t;
            exp_g1 = 1'b1;
            exp_g2 = 1'b0;
`endif
            exp_v = prev_own;
            chk($sformatf("hold.t%0d.g1", t), {7'd0, grant_1}, {7'd0, exp_g1});
            chk($sformatf("hold.t%0d.g2", t), {7'd0, grant_2}, {7'd0, exp_g2});
            chk($sformatf("hold.t%0d.v", t), {7'd0, bus_valid}, {7'd0, exp_v});
            prev_own = exp_g1 | exp_g2;
        end

        // Random requests: mutual exclusion and valid only after an ownership cycle.
        prev_own = grant_1 | grant_2;
        for (int t = 0; t < 200; t++) begin
            req_1 = 1'($urandom_range(0, 1));
            req_2 = 1'($urandom_range(0, 1));
            data_in_1 = 8'($urandom_range(0, 255));
            data_in_2 = 8'($urandom_range(0, 255));
            tick();
            chk("rand.excl", {7'd0, grant_1 & grant_2}, 8'h00);
            chk("rand.valid", {7'd0, bus_valid}, {7'd0, prev_own});
            prev_own = grant_1 | grant_2;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
